image_dilate_filtering_par: RTL and testbench
=============================================

Name: image_dilate_filtering_par

Overview:
- 3x3 binary dilation on a 4-pixel-parallel binary video stream; the counterpart of the parallel erosion stage in the morphology chain.
- Owns its own line buffers, handles neighbours across lane and beat boundaries, and zero-pads frame borders.
- Emits a complete output frame, flushing the last row internally.
- Sits between binarization and erosion (open/close pipeline) and uses the same valid/last/user stream framing.

Parameters:
- PARALLEL_NUM, 4, pixels per beat.
- PIXEL_WIDTH_R, 8, bits per pixel (binary 0/255; only bit0 is evaluated).
- TOTAL_BIN_WIDTH, PARALLEL_NUM*PIXEL_WIDTH_R, bus width.
- IMG_WIDTH, 1280, pixels per line; multiple of PARALLEL_NUM.
- IMG_HEIGHT, 720, lines per frame; must be at least 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_binary  in  TOTAL_BIN_WIDTH  pixel k (k=0..3) at bits [8k+7:8k]; pixel 0 is leftmost.
- i_valid  in  1  beat valid.
- i_user  in  1  start of frame; asserted with the first beat.
- i_last  in  1  end of line; asserted with the last beat of the line.
- o_binary  out  TOTAL_BIN_WIDTH  dilated pixels, 0 or 255 each, same lane order.
- o_valid  out  1  output beat valid.
- o_user  out  1  output start of frame.
- o_last  out  1  output end of line.
- o_bin_flag  out  PARALLEL_NUM  per-lane dilation result bit.
- o_err  out  2  sticky: [0] line-length error, [1] flush overrun.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - all outputs are 0 from the next cycle;
  - counters are 0 and state is IDLE;
  - pipeline contents are discarded;
  - line-buffer contents are don't-care (masked by the row counter).
- Definitions:
  - BPL = IMG_WIDTH/PARALLEL_NUM.
  - A pixel is set when bit0 = 1.
  - out(r,x) = OR of in(r+dr, x+dx) for dr, dx in {-1,0,+1}. Coordinates outside the frame read as 0. No horizontal wrap, no vertical wrap.
- Storage: two line buffers, BPL entries x PARALLEL_NUM bits.
- Horizontal neighbours:
  - lane -1 comes from the previous beat's lane 3;
  - lane 4 comes from the next beat's lane 0;
  - both are 0 at line ends.
- Trigger rules:
  - Output beat (r,c) with c<BPL-1 is triggered by acceptance of input beat (r+1,c+1).
  - Output beat (r,BPL-1) is triggered by the drain cycle, i.e. the cycle after row r+1's line-end beat is accepted.
  - Input beat (r+1,0) produces no output. An input beat accepted during a drain cycle is therefore legal.
- Latency: o_valid asserts exactly 2 cycles after each trigger.
- Stall tolerance: gaps (i_valid=0) are allowed anywhere; output content is gap-independent.
- Output framing:
  - o_user=1 only on output beat (0,0);
  - o_last=1 on every beat c=BPL-1;
  - o_binary, o_bin_flag, o_user and o_last are 0 whenever o_valid=0.
- States:
  - IDLE: accept only beats with i_user=1 (others dropped). SOF goes to ROW0 with row=0, col=1.
  - ROW0: store row 0, no output. On the line-end beat go to RUN, row=1.
  - RUN: store row r+1 and emit row r; the above-row is masked to 0 for r=0. The line-end beat of row IMG_HEIGHT-1 goes to FLUSH after its drain cycle.
  - FLUSH: inject a virtual all-zero row IMG_HEIGHT, BPL beats on consecutive cycles, followed by its drain cycle; this emits output row IMG_HEIGHT-1. Then go to IDLE. Duration is BPL+1 cycles.
- Input column counter:
  - wraps at i_last;
  - i_last at col != BPL-1, or col reaching BPL-1 without i_last, sets o_err[0]; the counter then realigns to 0 at the next beat.
- i_user=1 in ROW0 or RUN (early SOF): abandon the current frame with no further outputs for it; restart at ROW0, with this beat as (0,0).
- i_valid=1 during FLUSH: the beat is dropped and o_err[1] is set.
  - The flush completes unaffected.
  - Upstream guarantees a vertical blank of at least BPL+2 cycles.
- o_err bits clear only on reset.

Test Plan:
Bench parameters: IMG_WIDTH=16, IMG_HEIGHT=4 (BPL=4). Streams run gap-free unless noted.
- Single set pixel (1,4): beat 1 lane 0 -> output rows 0-2, cols 3-5 = 255 (spans beat 0 lane 3 and beat 1 lanes 0-1); all other pixels 0. Repeat with random i_valid gaps -> identical frame.
- Pixel (0,0) -> outputs (0..1, 0..1) = 255; col 15 and row 3 stay 0 (no wrap).
- Pixel (3,15) -> rows 2-3, cols 14-15 = 255; row 3 comes from FLUSH; o_last on the 4th flush beat; final o_valid at 3 cycles after the last input line-end beat + BPL+... per the trigger rules.
- All-255 frame -> 16 output beats, all 0xFFFFFFFF; o_user exactly once (first beat); 4 o_last; o_bin_flag=4'hF on every beat.
- i_valid pulse during FLUSH -> beat dropped, o_err=2'b10, flush output intact. Separate run: i_last at col 2 -> o_err[0]=1.
- i_rst high for one cycle mid-RUN -> all outputs 0 next cycle, no residual beats; the following frame matches the golden model.

Source files
------------

// File: rtl/image_dilate_filtering_par.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// image_dilate_filtering_par
//   3x3 binary dilation on a PARALLEL_NUM-pixel-per-beat binary video stream.
//   Keeps two line buffers of one bit per pixel and ORs the 3x3 window.
//   Pixels outside the frame read as 0. The last row is flushed internally
//   by injecting a virtual all-zero row after the frame.
//
//   Stream framing (input and output): a beat transfers on every clock edge
//   where *_valid is 1. There is no ready. *_user marks the first beat of a
//   frame and *_last marks the last beat of a line. On the output side,
//   data/user/last/flag are forced to 0 whenever o_valid is 0.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_binary              input pixels, lane k at [8k+7:8k], bit 0 evaluated
//   i_valid/i_user/i_last input beat valid, start of frame, end of line
//   o_binary              dilated pixels (0 or all ones per lane)
//   o_valid/o_user/o_last output beat valid, start of frame, end of line
//   o_bin_flag            per-lane dilation result bit
//   o_err                 sticky: [0] line length error, [1] flush overrun
// ---------------------------------------------------------------------------
module image_dilate_filtering_par #(
  parameter int PARALLEL_NUM    = 4,
  parameter int PIXEL_WIDTH_R   = 8,
  parameter int TOTAL_BIN_WIDTH = PARALLEL_NUM * PIXEL_WIDTH_R,
  parameter int IMG_WIDTH       = 1280,
  parameter int IMG_HEIGHT      = 720
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [TOTAL_BIN_WIDTH-1:0] i_binary,
  input  logic                       i_valid,
  input  logic                       i_user,
  input  logic                       i_last,
  output logic [TOTAL_BIN_WIDTH-1:0] o_binary,
  output logic                       o_valid,
  output logic                       o_user,
  output logic                       o_last,
  output logic [PARALLEL_NUM-1:0]    o_bin_flag,
  output logic [1:0]                 o_err
);

  localparam int BPL = IMG_WIDTH / PARALLEL_NUM;
  localparam int CW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int RW  = $clog2(IMG_HEIGHT + 1);
  localparam int FW  = $clog2(BPL + 2);

  typedef enum logic [1:0] {S_IDLE, S_ROW0, S_RUN, S_FLUSH} state_t;

  state_t                  state;
  logic [CW-1:0]           col_cnt;
  logic [RW-1:0]           row_cnt;
  logic [FW-1:0]           fl_cnt;

  // lb_new holds the row just above the incoming one, lb_old the row above it
  logic [PARALLEL_NUM-1:0] lb_new [BPL];
  logic [PARALLEL_NUM-1:0] lb_old [BPL];

  // Horizontal context: vertical OR of the last accepted beat and lane
  // PARALLEL_NUM-1 of the beat before it (0 at the start of a line).
  logic [PARALLEL_NUM-1:0] v_cur;
  logic                    v_left;
  logic                    drain_pend;

  // Operand stage feeding the output register
  logic                    s1_valid;
  logic                    s1_left;
  logic [PARALLEL_NUM-1:0] s1_mid;
  logic                    s1_right;
  logic                    s1_user;
  logic                    s1_last;

  logic [PARALLEL_NUM-1:0] in_pix;
  logic                    unused_bits;
  logic                    acc_real;
  logic                    sof;
  logic                    virt;
  logic                    bev;
  logic [CW-1:0]           b_col;
  logic [RW-1:0]           b_row;
  logic [PARALLEL_NUM-1:0] b_pix;
  logic                    col_end;
  logic                    b_end;
  logic                    emit;
  logic                    drain_go;
  logic [PARALLEL_NUM-1:0] v_up;
  logic [PARALLEL_NUM-1:0] v_mid;
  logic [PARALLEL_NUM-1:0] v_new;
  logic [PARALLEL_NUM+1:0] ext;
  logic [PARALLEL_NUM-1:0] dil;
  logic                    out_ok;

  // Only bit 0 of each lane carries information
  assign unused_bits = ^i_binary;

  always_comb begin
    in_pix = '0;
    for (int k = 0; k < PARALLEL_NUM; k++) in_pix[k] = i_binary[k*PIXEL_WIDTH_R];
  end

  // Real beats: in IDLE only a start-of-frame beat is taken; FLUSH drops all.
  assign acc_real = i_valid & ((state == S_IDLE) ? i_user : (state != S_FLUSH));
  assign sof      = acc_real & i_user;
  // Virtual zero beats of row IMG_HEIGHT occupy fl_cnt = 1..BPL
  assign virt     = (state == S_FLUSH) && (fl_cnt >= FW'(1)) && (fl_cnt <= FW'(BPL));
  assign bev      = acc_real | virt;

  always_comb begin
    if (sof)                    b_col = '0;
    else if (state == S_FLUSH)  b_col = CW'(fl_cnt - FW'(1));
    else                        b_col = col_cnt;
  end

  assign b_row   = sof ? '0 : row_cnt;
  assign b_pix   = virt ? '0 : in_pix;
  assign col_end = (b_col == CW'(BPL - 1));
  assign b_end   = bev & (col_end | (acc_real & i_last));
  // Beat c of row r+1 releases output beat c-1 of row r
  assign emit    = bev & (b_row != '0) & (b_col != '0);
  // A new frame abandons any drain still owed to the old one
  assign drain_go = drain_pend & ~sof;

  // Vertical OR; the row two above is absent while emitting output row 0
  assign v_up  = (b_row >= RW'(2)) ? lb_old[b_col] : '0;
  assign v_mid = (b_row >= RW'(1)) ? lb_new[b_col] : '0;
  assign v_new = b_pix | v_mid | v_up;

  // Horizontal OR across lane and beat boundaries; ext[0] is the left neighbour
  assign ext = {s1_right, s1_mid, s1_left};
  always_comb begin
    dil = '0;
    for (int k = 0; k < PARALLEL_NUM; k++) dil[k] = ext[k] | ext[k+1] | ext[k+2];
  end

  assign out_ok = s1_valid & ~sof;

  // Frame state, position counters and sticky errors
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      fl_cnt  <= '0;
      o_err   <= '0;
    end else begin
      if (acc_real && (i_last != col_end)) o_err[0] <= 1'b1;
      if (i_valid && (state == S_FLUSH))   o_err[1] <= 1'b1;
      if (state == S_FLUSH) begin
        if (fl_cnt == FW'(BPL + 1)) begin
          state   <= S_IDLE;
          row_cnt <= '0;
          col_cnt <= '0;
          fl_cnt  <= '0;
        end else begin
          fl_cnt <= fl_cnt + FW'(1);
        end
      end else if (acc_real) begin
        col_cnt <= b_end ? '0 : b_col + CW'(1);
        if (b_end) begin
          if (b_row == RW'(IMG_HEIGHT - 1)) begin
            state   <= S_FLUSH;
            row_cnt <= RW'(IMG_HEIGHT);
            fl_cnt  <= '0;
          end else begin
            state   <= S_RUN;
            row_cnt <= b_row + RW'(1);
          end
        end else if (sof) begin
          state   <= S_ROW0;
          row_cnt <= '0;
        end
      end
    end
  end

  // Line buffers: contents before the first row are masked via b_row
  always_ff @(posedge i_clk) begin
    if (bev) begin
      lb_old[b_col] <= lb_new[b_col];
      lb_new[b_col] <= b_pix;
    end
  end

  // Window context, operand stage and output register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_cur      <= '0;
      v_left     <= 1'b0;
      drain_pend <= 1'b0;
      s1_valid   <= 1'b0;
      s1_left    <= 1'b0;
      s1_mid     <= '0;
      s1_right   <= 1'b0;
      s1_user    <= 1'b0;
      s1_last    <= 1'b0;
      o_valid    <= 1'b0;
      o_user     <= 1'b0;
      o_last     <= 1'b0;
      o_bin_flag <= '0;
      o_binary   <= '0;
    end else begin
      if (bev) begin
        v_left <= (b_col == '0) ? 1'b0 : v_cur[PARALLEL_NUM-1];
        v_cur  <= v_new;
      end
      drain_pend <= b_end & (b_row != '0);
      s1_valid   <= emit | drain_go;
      s1_left    <= v_left;
      s1_mid     <= v_cur;
      if (drain_go) begin
        // Last beat of the line: nothing to the right
        s1_right <= 1'b0;
        s1_user  <= 1'b0;
        s1_last  <= 1'b1;
      end else begin
        s1_right <= v_new[0];
        s1_user  <= (b_row == RW'(1)) && (b_col == CW'(1));
        s1_last  <= 1'b0;
      end
      o_valid    <= out_ok;
      o_user     <= out_ok & s1_user;
      o_last     <= out_ok & s1_last;
      o_bin_flag <= out_ok ? dil : '0;
      for (int k = 0; k < PARALLEL_NUM; k++)
        o_binary[k*PIXEL_WIDTH_R +: PIXEL_WIDTH_R] <= {PIXEL_WIDTH_R{out_ok & dil[k]}};
    end
  end

endmodule

// File: tb/tb_image_dilate_filtering_par.sv
`timescale 1ns/1ps
module tb_image_dilate_filtering_par;

  localparam int P   = 4;
  localparam int PW  = 8;
  localparam int TW  = P * PW;
  localparam int IW  = 16;
  localparam int IH  = 4;
  localparam int BPL = IW / P;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [TW-1:0] i_binary = '0;
  logic          i_valid = 1'b0;
  logic          i_user = 1'b0;
  logic          i_last = 1'b0;
  logic [TW-1:0] o_binary;
  logic          o_valid;
  logic          o_user;
  logic          o_last;
  logic [P-1:0]  o_bin_flag;
  logic [1:0]    o_err;

  image_dilate_filtering_par #(
    .PARALLEL_NUM(P), .PIXEL_WIDTH_R(PW), .TOTAL_BIN_WIDTH(TW),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_binary(i_binary), .i_valid(i_valid),
    .i_user(i_user), .i_last(i_last), .o_binary(o_binary), .o_valid(o_valid),
    .o_user(o_user), .o_last(o_last), .o_bin_flag(o_bin_flag), .o_err(o_err)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit img [IH][IW];
  logic [37:0] exp_q [$];   // {user, last, flag[3:0], binary[31:0]}
  logic [37:0] cap_q [$];
  int idle_bad = 0;
  int last_vcyc = 0;
  int user_cyc = 0;
  int t11 = 0;
  int t_end = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge i_clk) begin
    if (o_valid) begin
      cap_q.push_back({o_user, o_last, o_bin_flag, o_binary});
      last_vcyc = cyc;
      if (o_user) user_cyc = cyc;
    end else if (o_user || o_last || (|o_bin_flag) || (|o_binary)) begin
      idle_bad++;
    end
  end

  function automatic logic [31:0] cap_bin(input int i);
    if (cap_q.size() > i) return cap_q[i][31:0];
    return 'x;
  endfunction

  // ---------------- golden model ----------------
  task automatic clear_img();
    for (int r = 0; r < IH; r++)
      for (int x = 0; x < IW; x++) img[r][x] = 1'b0;
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < BPL; c++) begin
        logic [31:0] bin;
        logic [3:0]  flg;
        bin = '0;
        flg = '0;
        for (int k = 0; k < P; k++) begin
          bit v;
          v = 1'b0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dx = -1; dx <= 1; dx++) begin
              int rr, xx;
              rr = r + dr;
              xx = c * P + k + dx;
              if (rr >= 0 && rr < IH && xx >= 0 && xx < IW && img[rr][xx]) v = 1'b1;
            end
          flg[k] = v;
          bin[k*PW +: PW] = {PW{v}};
        end
        exp_q.push_back({(r == 0 && c == 0), (c == BPL - 1), flg, bin});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    i_binary = d;
    i_valid  = 1'b1;
    i_user   = u;
    i_last   = l;
    @(posedge i_clk);
    #1;
    i_binary = '0;
    i_valid  = 1'b0;
    i_user   = 1'b0;
    i_last   = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int n_beats);
    int n;
    n = 0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < BPL; c++) begin
        logic [31:0] d;
        for (int k = 0; k < P; k++) d[k*PW +: PW] = img[r][c*P+k] ? 8'hFF : 8'h00;
        if (n < n_beats) begin
          if (gaps) idle($urandom_range(0, 2));
          send_beat(d, (r == 0 && c == 0), (c == BPL - 1));
          if (r == 1 && c == 1) t11 = cyc;
          t_end = cyc;
        end
        n++;
      end
  endtask

  task automatic start_capture();
    cap_q.delete();
    idle_bad = 0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_cnt"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), (cap_q.size() > i) ? 64'(cap_q[i]) : 64'hx, 64'(exp_q[i]));
    check({tag, "_idle_zero"}, 64'(idle_bad), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nu, nl;
    i_rst = 1'b1;
    idle(3);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_outs", {o_user, o_last, o_bin_flag, o_binary}, 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    i_rst = 1'b0;
    idle(2);

    // Single set pixel (1,4)
    clear_img(); img[1][4] = 1'b1; build_exp();
    start_capture(); send_frame(1'b0, 16); idle(12);
    compare_frame("px14");
    check("px14_b0_hand", 64'(cap_bin(0)), 64'hFF000000);
    check("px14_b1_hand", 64'(cap_bin(1)), 64'h0000FFFF);
    check("px14_b8_hand", 64'(cap_bin(8)), 64'hFF000000);
    check("px14_b12_hand", 64'(cap_bin(12)), 64'h0);
    check("px14_lat_first", 64'(user_cyc), 64'(t11 + 1));

    // Same frame with random input gaps
    start_capture(); send_frame(1'b1, 16); idle(12);
    compare_frame("px14_gaps");

    // Corner pixel (0,0): no wrap into col 15 or row 3
    clear_img(); img[0][0] = 1'b1; build_exp();
    start_capture(); send_frame(1'b0, 16); idle(12);
    compare_frame("px00");
    check("px00_b0_hand", 64'(cap_bin(0)), 64'h0000FFFF);
    check("px00_b3_hand", 64'(cap_bin(3)), 64'h0);
    check("px00_b4_hand", 64'(cap_bin(4)), 64'h0000FFFF);
    check("px00_b12_hand", 64'(cap_bin(12)), 64'h0);

    // Corner pixel (3,15): row 3 comes out of the flush
    clear_img(); img[3][15] = 1'b1; build_exp();
    start_capture(); send_frame(1'b0, 16); idle(12);
    compare_frame("px315");
    check("px315_b11_hand", 64'(cap_bin(11)), 64'hFFFF0000);
    check("px315_b15_hand", 64'(cap_bin(15)), 64'hFFFF0000);
    check("px315_b15_last", (cap_q.size() > 15) ? 64'(cap_q[15][36]) : 64'hx, 64'd1);
    check("px315_lat_final", 64'(last_vcyc), 64'(t_end + BPL + 3));
    check("err_clean", 64'(o_err), 64'd0);

    // All-ones frame
    for (int r = 0; r < IH; r++) for (int x = 0; x < IW; x++) img[r][x] = 1'b1;
    build_exp();
    start_capture(); send_frame(1'b0, 16); idle(12);
    compare_frame("ones");
    nu = 0; nl = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i][37]) nu++;
      if (cap_q[i][36]) nl++;
    end
    check("ones_users", 64'(nu), 64'd1);
    check("ones_lasts", 64'(nl), 64'd4);

    // Beat during FLUSH is dropped and flagged
    do_reset();
    clear_img(); img[2][8] = 1'b1; build_exp();
    start_capture(); send_frame(1'b0, 16);
    idle(2);
    send_beat(32'hFFFFFFFF, 1'b1, 1'b1);
    idle(12);
    compare_frame("flush_pulse");
    check("flush_err", 64'(o_err), 64'd2);

    // Short line sets the line-length error
    do_reset();
    check("err_after_rst", 64'(o_err), 64'd0);
    send_beat(32'h0, 1'b1, 1'b0);
    send_beat(32'h0, 1'b0, 1'b0);
    send_beat(32'h0, 1'b0, 1'b1);
    idle(2);
    check("line_err", 64'(o_err), 64'd1);
    do_reset();

    // One-cycle reset in the middle of a frame
    for (int r = 0; r < IH; r++) for (int x = 0; x < IW; x++) img[r][x] = 1'b1;
    send_frame(1'b0, 10);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    start_capture();
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_outs", {o_user, o_last, o_bin_flag, o_binary}, 64'd0);
    idle(10);
    check("mid_rst_no_residue", 64'(cap_q.size()), 64'd0);
    clear_img(); img[1][4] = 1'b1; build_exp();
    start_capture(); send_frame(1'b0, 16); idle(12);
    compare_frame("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
